data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, the number of 32-bit memory words.
REQ-002 The block SHALL have parameter WAIT, default 2, the number of wait cycles inserted before a response (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, 1, the initiator request, held until ready.
REQ-006 The block SHALL have port we, input, 1, the write enable: 1 = store, 0 = load.
REQ-007 The block SHALL have port addr, input, 32, the byte address; word index is addr[31:2].
REQ-008 The block SHALL have port wdata, input, 32, the store data.
REQ-009 The block SHALL have port rdata, output, 32, the load data, registered.
REQ-010 The block SHALL have port ready, output, 1, a one-cycle response strobe.
REQ-011 The block SHALL have port err, output, 1, the access-fault flag, valid with ready.
REQ-012 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-014 In IDLE with req=1, the block SHALL accept: capture we, addr and wdata into internal registers, and load the wait counter with WAIT.
REQ-015 On acceptance, the FSM SHALL go IDLE->WAIT if WAIT>0, and IDLE->RESP if WAIT=0.
REQ-016 In WAIT, the counter SHALL decrement by 1 per cycle, and the FSM SHALL go WAIT->RESP on the cycle the counter reaches 1.
REQ-017 In RESP, ready SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE unconditionally.
REQ-018 The latency from the acceptance edge to ready high SHALL be WAIT+1 cycles.
REQ-019 Input changes on we, addr or wdata after acceptance SHALL be ignored; only the captured values are used.
REQ-020 A new request SHALL be accepted no earlier than the cycle after RESP; a held req yields back-to-back transactions of WAIT+2 cycles each.
REQ-021 A store SHALL write the captured wdata to the captured word index on the RESP edge.
REQ-022 A load SHALL update rdata with the word at the captured index on the RESP edge.
REQ-023 rdata SHALL hold its value until the next load response.
REQ-024 A fault SHALL be detected when addr[1:0] != 0 or addr[31:2] >= DEPTH.
REQ-025 On a fault, the block SHALL assert err together with ready, perform no memory write, and load rdata with 0.
REQ-026 On a non-fault response, err SHALL be 0; err SHALL be 0 whenever ready is 0.
REQ-027 Store then load of the same word SHALL return the stored value with no hazard.

Reset
REQ-028 While reset is 0, the state SHALL be IDLE and the counter, rdata, ready, err, busy and the captured registers SHALL all be 0.
REQ-029 Reset asserted during WAIT or RESP SHALL abort the transaction, discard any pending store, and suppress ready.
REQ-030 Memory array contents SHALL NOT be altered by reset.
REQ-031 Acceptance SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-032 With macro DMEM_RESP_FAST_WRITE_EN defined, stores SHALL bypass the wait counter and go IDLE->RESP, giving 1-cycle store latency regardless of WAIT; loads SHALL keep WAIT+1 latency.
REQ-033 Without DMEM_RESP_FAST_WRITE_EN, loads and stores SHALL both have WAIT+1 cycle latency.

Verification (DEPTH=64, WAIT=2, macro undefined unless stated)
REQ-034 The bench SHALL cover: store 0x00000A00 to addr 0x60 with req held -> ready=1, err=0 on the 3rd edge after acceptance, busy=1 for 3 cycles.
REQ-035 The bench SHALL cover: load addr 0x60 after that store -> rdata=0x00000A00, err=0, ready on the 3rd edge.
REQ-036 The bench SHALL cover: load addr 0x62 and store to addr 0x100 -> each gives err=1 with ready and rdata=0, and a later load of word 0 (addr 0x000) is unchanged.
REQ-037 The bench SHALL cover: store 0x12345678 to addr 0x04 with reset pulsed low during WAIT -> no ready, and a later load of 0x04 returns the old value.
REQ-038 The bench SHALL cover: req held for two loads -> ready pulses exactly 4 cycles apart.
REQ-039 The bench SHALL cover, with DMEM_RESP_FAST_WRITE_EN defined: store to 0x08 -> ready on the 1st edge after acceptance; load of 0x08 -> ready on the 3rd edge.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with a fixed wait-state response FSM.
// Optional macro DMEM_RESP_FAST_WRITE_EN: stores skip the wait states and respond in one cycle.
module data_mem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic               accept;
  logic               cap_we;
  logic [31:0]        cap_addr;
  logic [31:0]        cap_wdata;
  logic               fault;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        mem [DEPTH];

  assign idx   = cap_addr[IDX_W+1:2];
  assign fault = (cap_addr[1:0] != 2'b00) || ({2'b00, cap_addr[31:2]} >= 32'(DEPTH));
  assign busy  = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_nxt = 4'(WAIT);
`ifdef DMEM_RESP_FAST_WRITE_EN
          if (we || WAIT == 0) state_nxt = ST_RESP;
          else                 state_nxt = ST_WAIT;
`else
          if (WAIT == 0) state_nxt = ST_RESP;
          else           state_nxt = ST_WAIT;
`endif
        end
      end
      ST_WAIT: begin
        // The WAIT state lasts exactly WAIT cycles: leave when the count is at 1.
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        cnt_nxt   = 4'd0;
        state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = 4'd0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      rdata     <= 32'd0;
      ready     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_we    <= we;
        cap_addr  <= addr;
        cap_wdata <= wdata;
      end
      // Response outputs are registered on the edge that leaves RESP, so rdata and ready line up.
      ready <= (state == ST_RESP);
      err   <= (state == ST_RESP) && fault;
      if (state == ST_RESP) begin
        if (fault)        rdata <= 32'd0;
        else if (!cap_we) rdata <= mem[idx];
      end
    end
  end

  // Memory has no reset; an asynchronous reset forces IDLE, which blocks any pending store.
  always_ff @(posedge clk) begin
    if (state == ST_RESP && cap_we && !fault) mem[idx] <= cap_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (DEPTH=64, WAIT=2); store latency follows DMEM_RESP_FAST_WRITE_EN.
`timescale 1ns/1ps
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready, err, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ready_cyc = 0;
  int prev_ready_cyc = 0;

`ifdef DMEM_RESP_FAST_WRITE_EN
  localparam int LAT_ST = 1;
`else
  localparam int LAT_ST = 3;
`endif
  localparam int LAT_LD = 3;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } exp_t;

  exp_t q[$];

  data_mem_responder #(.DEPTH(64), .WAIT(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req_v);
    end
  endtask

  // Monitor: pops one expectation per ready pulse.
  always @(negedge clk) begin
    if (reset) begin
      if (ready) begin
        prev_ready_cyc = last_ready_cyc;
        last_ready_cyc = cyc;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got ready at edge %0d expected none", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("ready_edge", 32'(cyc), 32'(e.cyc));
          check("err", {31'd0, err}, {31'd0, e.err});
          if (e.chk) check("rdata", rdata, e.rdata);
        end
      end else if (err) begin
        checks++;
        errors++;
        $display("FAIL err_without_ready: got err=1 expected 0");
      end
    end
  end

  // Issue one transaction, scramble inputs after acceptance, wait for the FSM to return to IDLE.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd,
                     input logic hold);
    int acc;
    int nbusy;
    exp_t e;
    int lat;
    lat = w ? LAT_ST : LAT_LD;
    check("idle_before_req", {31'd0, busy}, 32'd0);
    we = w; addr = a; wdata = d; req = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    e.cyc = acc + lat; e.rdata = exp_rd; e.err = exp_err; e.chk = chk_rd;
    q.push_back(e);
    we = ~w; addr = ~a; wdata = ~d;
    if (!hold) req = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 20) begin
      nbusy++;
      @(posedge clk); #1;
    end
    check("busy_cycles", 32'(nbusy), 32'(lat));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Seed known contents; the first request lands on the first edge after reset release.
    txn(1'b1, 32'h04, 32'h0000BEEF, 32'd0, 1'b0, 1'b0, 1'b0);
    txn(1'b1, 32'h00, 32'h11111111, 32'd0, 1'b0, 1'b0, 1'b0);
    txn(1'b1, 32'hFC, 32'h5A5A5A5A, 32'd0, 1'b0, 1'b0, 1'b0);
    txn(1'b0, 32'hFC, 32'd0, 32'h5A5A5A5A, 1'b0, 1'b1, 1'b0);

    // Store with req held, then back-to-back load of the same word.
    txn(1'b1, 32'h60, 32'h00000A00, 32'd0, 1'b0, 1'b0, 1'b1);
    txn(1'b0, 32'h60, 32'd0, 32'h00000A00, 1'b0, 1'b1, 1'b0);

    // Faults: misaligned load, out-of-range store; word 0 untouched.
    txn(1'b0, 32'h62, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    txn(1'b1, 32'h100, 32'hDEADDEAD, 32'd0, 1'b1, 1'b1, 1'b0);
    txn(1'b0, 32'h00, 32'd0, 32'h11111111, 1'b0, 1'b1, 1'b0);

    // Reset pulsed during WAIT aborts the store.
    @(posedge clk); #1;
    we = 1'b1; addr = 32'h04; wdata = 32'h12345678; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check("abort_busy_in_wait", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #2;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    txn(1'b0, 32'h04, 32'd0, 32'h0000BEEF, 1'b0, 1'b1, 1'b0);

    // Two loads with req held: ready pulses 4 cycles apart.
    txn(1'b0, 32'h00, 32'd0, 32'h11111111, 1'b0, 1'b1, 1'b1);
    txn(1'b0, 32'h60, 32'd0, 32'h00000A00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("ready_spacing", 32'(last_ready_cyc - prev_ready_cyc), 32'd4);

    // Store to 0x08 then load (store latency depends on the build).
    txn(1'b1, 32'h08, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0, 1'b0);
    txn(1'b0, 32'h08, 32'd0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
